// File: rtl/watch_display_scan.sv
// 6-digit multiplexed 7-segment scanner for the watch time digits, with a per-frame snapshot
// and a one-cycle anti-ghosting blank slot. Define DP_BLINK_EN to blink the separators at 1 Hz.
module watch_display_scan #(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned DIGIT_HZ       = 1200,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] s_unidade,
  input  logic [3:0] s_dezena,
  input  logic [3:0] m_unidade,
  input  logic [3:0] m_dezena,
  input  logic [3:0] h_unidade,
  input  logic [3:0] h_dezena,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic [2:0] digit_idx,
  output logic       frame_start
);

  localparam int unsigned DIV = CLK_HZ / DIGIT_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("watch_display_scan: CLK_HZ/DIGIT_HZ must be >= 2");
  end

  // Prescaler and slot sequencing
  logic [PW-1:0]     pre_q;
  logic [2:0]        idx_q;
  logic [2:0]        idx_next;
  logic              tick;
  logic              wrap;
  logic              show_q;
  logic              fs_q;
  logic [5:0][3:0]   shadow_q;

  // Output registers are kept active-high; polarity is applied at the ports.
  logic [5:0]        an_q;
  logic [6:0]        seg_q;
  logic              dp_q;

  logic [3:0]        cur_digit;
  logic [5:0]        an_d;
  logic [6:0]        seg_d;
  logic              dp_d;
  logic              sep;
  logic              blink_on;

  assign tick     = (pre_q == PRE_MAX);
  assign idx_next = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
  assign wrap     = tick && (idx_q == 3'd5);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q    <= '0;
      idx_q    <= 3'd5;
      show_q   <= 1'b0;
      fs_q     <= 1'b0;
      shadow_q <= '0;
      an_q     <= '0;
      seg_q    <= '0;
      dp_q     <= 1'b0;
    end else begin
      pre_q  <= tick ? '0 : pre_q + 1'b1;
      show_q <= tick;
      fs_q   <= wrap;
      if (tick) begin
        idx_q <= idx_next;
      end
      // Snapshot only at the frame boundary so one frame never mixes two seconds.
      if (wrap) begin
        shadow_q <= {h_dezena, h_unidade, m_dezena, m_unidade, s_dezena, s_unidade};
      end
      if (tick) begin
        an_q <= '0;
      end else if (show_q) begin
        an_q  <= an_d;
        seg_q <= seg_d;
        dp_q  <= dp_d;
      end
    end
  end

  always_comb begin
    cur_digit = shadow_q[0];
    case (idx_q)
      3'd1:    cur_digit = shadow_q[1];
      3'd2:    cur_digit = shadow_q[2];
      3'd3:    cur_digit = shadow_q[3];
      3'd4:    cur_digit = shadow_q[4];
      3'd5:    cur_digit = shadow_q[5];
      default: cur_digit = shadow_q[0];
    endcase
  end

  // Active-high g..a patterns; non-BCD shows a dash.
  always_comb begin
    seg_d = 7'b1000000;
    case (cur_digit)
      4'd0:    seg_d = 7'b0111111;
      4'd1:    seg_d = 7'b0000110;
      4'd2:    seg_d = 7'b1011011;
      4'd3:    seg_d = 7'b1001111;
      4'd4:    seg_d = 7'b1100110;
      4'd5:    seg_d = 7'b1101101;
      4'd6:    seg_d = 7'b1111101;
      4'd7:    seg_d = 7'b0000111;
      4'd8:    seg_d = 7'b1111111;
      4'd9:    seg_d = 7'b1101111;
      default: seg_d = 7'b1000000;
    endcase
    if ((idx_q == 3'd5) && blank_lz && (cur_digit == 4'd0)) begin
      seg_d = 7'b0000000;
    end
  end

  always_comb begin
    an_d = '0;
    case (idx_q)
      3'd0:    an_d = 6'b000001;
      3'd1:    an_d = 6'b000010;
      3'd2:    an_d = 6'b000100;
      3'd3:    an_d = 6'b001000;
      3'd4:    an_d = 6'b010000;
      3'd5:    an_d = 6'b100000;
      default: an_d = 6'b000000;
    endcase
  end

  assign sep  = (idx_q == 3'd2) || (idx_q == 3'd4);
  assign dp_d = sep && blink_on;

`ifdef DP_BLINK_EN
  localparam int unsigned HALF = ((DIGIT_HZ / 2) > 0) ? (DIGIT_HZ / 2) : 1;
  localparam int unsigned BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);

  logic [BW-1:0] blink_cnt_q;
  logic          blink_q;

  // Counts slot ticks; toggling every DIGIT_HZ/2 ticks gives a 1 Hz blink.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else if (tick) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign blink_on = blink_q;
`else
  assign blink_on = 1'b1;
`endif

  assign seg         = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign dp          = SEG_ACTIVE_LOW ? ~dp_q : dp_q;
  assign an          = AN_ACTIVE_LOW ? ~an_q : an_q;
  assign digit_idx   = idx_q;
  assign frame_start = fs_q;

endmodule
